branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch direction predictor feeding the EX-stage control's `br_taken` input and consuming its `br_suc` / `br_mispred` feedback. Holds a PC-indexed table of 2-bit saturating counters. It predicts in decode and registers the prediction into EX alongside the branch. It trains the table when the branch resolves and keeps 32-bit branch and mispredict statistics counters for the CSR path.

## Interface
- `ENTRIES`, 64, number of counters; power of two, ≥ 2; `IDX_W = log2(ENTRIES)`.
- `clk` input 1: sole clock, all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `lookup_pc` input 32: PC of the instruction currently in decode.
- `lookup_en` input 1: decode instruction is a conditional branch (opcode BRANCH).
- `stall` input 1: pipeline hold; the EX-stage register keeps its value.
- `flush` input 1: kill the instruction entering EX (mispredict redirect).
- `ex_pc` input 32: PC of the instruction in EX.
- `br_suc` input 1: EX branch resolved, prediction correct.
- `br_mispred` input 1: EX branch resolved, prediction wrong.
- `pred_taken` output 1: combinational decode-stage prediction.
- `ex_br_taken` output 1: registered prediction for the EX instruction; drives EX control `br_taken`.
- `branch_cnt` output 32: resolved branches retired from EX.
- `mispred_cnt` output 32: mispredicted branches retired from EX.

## Operation
- **Table:** `ENTRIES` 2-bit counters. Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Indexing:** lookup index is `lookup_pc[IDX_W+1:2]`. Update index is `ex_pc[IDX_W+1:2]`. Upper PC bits are ignored, so aliasing is permitted.
- **Prediction:** `pred_taken = lookup_en & counter[lookup_idx][1]`. It is 0 whenever `lookup_en` = 0.
- **Update event:** `upd = (br_suc | br_mispred) & ~stall`. Training happens only on the cycle the branch leaves EX, so a stalled branch is counted exactly once.
- **Actual direction:** `actual = ex_br_taken ^ br_mispred`.
- **Counter rule:** on `upd`, the counter steps +1 toward 11 if `actual` = 1, or −1 toward 00 if `actual` = 0. It saturates at both ends and never wraps.
- **Illegal input:** `br_suc` and `br_mispred` both high is handled as a mispredict.
- **Same-index bypass:** if `upd` and the lookup index equals the update index in the same cycle, `pred_taken` uses the post-update counter value.
- **EX register:** `ex_br_taken` is priority-ordered:
  - `rst` → 0;
  - else `flush` → 0;
  - else `stall` → hold;
  - else `ex_br_taken <= pred_taken`.
- **Statistics:** on `upd`, `branch_cnt` += 1, and `mispred_cnt` += 1 if `br_mispred`. Both counters wrap modulo 2^32.
- The block has no FSM beyond the table and EX register. All state is architectural-invisible except the statistics counters.

## Timing
- **Reset:** all table entries 01 (weak-NT); `ex_br_taken` = 0; `branch_cnt` = 0; `mispred_cnt` = 0. Consequently `pred_taken` = 0 for every PC after reset.
- **Reset mid-operation:** `rst` overrides any concurrent `upd`, `flush` or `stall`. The table and counters are reinitialised on that edge.
- **Prediction latency:** `pred_taken` is valid in the same cycle as `lookup_pc` / `lookup_en` (0 cycles). It appears on `ex_br_taken` 1 cycle later, absent stall.
- **Update latency:** the table write lands at the posedge of the `upd` cycle and is visible to lookups in the next cycle. Through the bypass it is already visible in the same cycle.
- **Flush and stall together:** `flush` wins, so `ex_br_taken` → 0.
- **Update during flush:** an update on a cycle with `flush` = 1 is still applied. The resolving branch is the cause of the flush, not its victim.
- **Stall suppression:** when `stall` = 1, no counter, table or `ex_br_taken` change occurs, even if `br_suc` / `br_mispred` are high.

## Test plan
- **Reset, predict, train:** after reset, lookup PC 0x1000 with `lookup_en` = 1 → `pred_taken` = 0. One `upd` with `ex_pc` = 0x1000, `ex_br_taken` = 0, `br_mispred` = 1 → entry 10, next lookup → `pred_taken` = 1, `branch_cnt` = 1, `mispred_cnt` = 1.
- **Saturation:** 5 consecutive taken resolutions (`br_suc` with `ex_br_taken` = 1) at PC 0x2004 → entry 11, no wrap. Then 1 mispredict → 10, prediction still taken. Then 2 more → 00 after three total steps down, `pred_taken` = 0.
- **Aliasing and bypass:** PCs 0x0100 and 0x0200 with ENTRIES = 64 share index 0. Train 0x0100 to taken → lookup 0x0200 predicts taken. With same-cycle `upd` (01→10) and lookup of that index → `pred_taken` = 1 in that cycle.
- **Stall/flush:** `br_mispred` = 1 held for 3 cycles with `stall` = 1 then 1 cycle with `stall` = 0 → exactly one counter step, `mispred_cnt` += 1. With `pred_taken` = 1 and `stall` = `flush` = 1 → `ex_br_taken` = 0 next cycle. With `stall` only → `ex_br_taken` holds.
- **Counter wrap and mid-run reset:** force `branch_cnt` to 0xFFFFFFFF, one `upd` → 0x00000000. Assert `rst` concurrently with an `upd` → all outputs 0 and a trained entry reads weak-NT (`pred_taken` = 0).
- **Non-branch lookup:** `lookup_en` = 0 on a PC whose entry is 11 → `pred_taken` = 0 and `ex_br_taken` = 0 on the next edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: PC-indexed table of 2-bit saturating
// counters, a registered EX-stage prediction, and 32-bit resolution statistics.
module branch_predictor #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    input  logic        lookup_en,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ex_pc,
    input  logic        br_suc,
    input  logic        br_mispred,
    output logic        pred_taken,
    output logic        ex_br_taken,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             upd;
    logic             actual;
    logic [1:0]       upd_ctr_cur;
    logic [1:0]       upd_ctr_next;
    logic [1:0]       lookup_ctr;
    logic [1:0]       ctr_q [ENTRIES];
    logic             ex_br_taken_reg;
    logic [31:0]      branch_cnt_reg;
    logic [31:0]      mispred_cnt_reg;

    // Upper and byte-offset PC bits are intentionally ignored (aliasing allowed).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                              ex_pc[31:IDX_W+2], ex_pc[1:0]};

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign upd_idx    = ex_pc[IDX_W+1:2];

    // A stalled branch is still sitting in EX, so it trains only once it leaves.
    assign upd = (br_suc | br_mispred) & ~stall;

    // Both feedback lines high is treated as a mispredict, which falls out of
    // using br_mispred alone to flip the registered prediction.
    assign actual = ex_br_taken_reg ^ br_mispred;

    // Saturating step of the counter addressed by the resolving branch.
    always_comb begin
        upd_ctr_cur  = ctr_q[upd_idx];
        upd_ctr_next = upd_ctr_cur;
        if (actual) begin
            if (upd_ctr_cur != CTR_MAX) begin
                upd_ctr_next = upd_ctr_cur + 2'd1;
            end
        end else begin
            if (upd_ctr_cur != CTR_MIN) begin
                upd_ctr_next = upd_ctr_cur - 2'd1;
            end
        end
    end

    // One counter register per table entry; reset must reinitialise every
    // entry in a single edge, so the table lives in flops rather than RAM.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(gi);
            logic [1:0] ctr_reg;

            // Write this entry when the resolving branch maps onto it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctr_reg <= CTR_RESET;
                end else if (upd && (upd_idx == MY_IDX)) begin
                    ctr_reg <= upd_ctr_next;
                end
            end

            assign ctr_q[gi] = ctr_reg;
        end
    endgenerate

    // Decode-stage lookup with same-cycle bypass of a pending update.
    always_comb begin
        lookup_ctr = ctr_q[lookup_idx];
        if (upd && (lookup_idx == upd_idx)) begin
            lookup_ctr = upd_ctr_next;
        end
        pred_taken = lookup_en & lookup_ctr[1];
    end

    // EX-stage prediction register: flush beats stall, stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_br_taken_reg <= 1'b0;
        end else if (flush) begin
            ex_br_taken_reg <= 1'b0;
        end else if (!stall) begin
            ex_br_taken_reg <= pred_taken;
        end
    end

    // Resolution statistics, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_reg  <= 32'd0;
            mispred_cnt_reg <= 32'd0;
        end else if (upd) begin
            branch_cnt_reg <= branch_cnt_reg + 32'd1;
            if (br_mispred) begin
                mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            end
        end
    end

    assign ex_br_taken = ex_br_taken_reg;
    assign branch_cnt  = branch_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;

endmodule
